// File: rtl/ioctl_loader_bridge.sv
// Buffers the HPS ioctl download stream in a small FIFO and hands bytes to the
// core loader port with a strobe/acknowledge handshake; latches done after one image.
module ioctl_loader_bridge #(
    parameter int         DEPTH = 4,
    parameter int         AW    = 20,
    parameter logic [7:0] INDEX = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic [AW-1:0] ldr_addr,
    output logic [7:0]    ldr_wdat,
    output logic          ldr_aen,
    output logic          ldr_wr,
    input  logic          ldr_ack,
    output logic          ldr_done,
    output logic          ldr_overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [AW+7:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            old_download, old_ack;
    logic            index_ok, in_range, full, empty;
    logic            req, push, drop, pop, start;
    logic [AW+7:0]   head;

    assign index_ok = (INDEX == 8'hFF) || (ioctl_index == INDEX);
    assign in_range = (ioctl_addr >> AW) == 25'd0;
    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign req      = (state == LOAD) && ioctl_wr && index_ok;
    assign push     = req && in_range && !full;
    assign drop     = req && (!in_range || full);
    assign pop      = ldr_wr && ldr_ack && !old_ack;
    // An empty FIFO forwards the incoming byte so the strobe rises one cycle after ioctl_wr.
    assign head     = empty ? {ioctl_addr[AW-1:0], ioctl_dout} : mem[rd_ptr];
    assign start    = !ldr_wr && (!empty || push);

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {ioctl_addr[AW-1:0], ioctl_dout};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            old_download <= 1'b0;
            old_ack      <= 1'b0;
            ldr_wr       <= 1'b0;
            ldr_addr     <= '0;
            ldr_wdat     <= '0;
            ldr_overflow <= 1'b0;
        end else begin
            state        <= state_next;
            old_download <= ioctl_download;
            old_ack      <= ldr_ack;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) ldr_overflow <= 1'b1;
            // Address/data are captured only when the strobe rises, so they hold while it is high.
            if (pop) begin
                ldr_wr <= 1'b0;
            end else if (start) begin
                ldr_wr   <= 1'b1;
                ldr_addr <= head[AW+7:8];
                ldr_wdat <= head[7:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        ldr_aen    = 1'b0;
        ldr_done   = 1'b0;
        ioctl_wait = 1'b0;
        case (state)
            IDLE:  if (ioctl_download && !old_download && index_ok) state_next = LOAD;
            LOAD: begin
                ldr_aen    = 1'b1;
                ioctl_wait = count >= CW'(DEPTH - 1);
                if (!ioctl_download && old_download) state_next = DRAIN;
            end
            DRAIN: begin
                ldr_aen = 1'b1;
                if (empty && !ldr_wr) state_next = DONE;
            end
            DONE:  ldr_done = 1'b1;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// Scoreboard bench: stimulus queues expected loader writes, a negedge monitor
// plays the core side (ack with programmable delay) and checks each strobe.
module tb_ioctl_loader_bridge;
    logic        clk_sys = 0;
    logic        reset = 1;
    logic        ioctl_download = 0;
    logic [7:0]  ioctl_index = 0;
    logic        ioctl_wr = 0;
    logic [24:0] ioctl_addr = 0;
    logic [7:0]  ioctl_dout = 0;
    logic        ioctl_wait;
    logic [19:0] ldr_addr;
    logic [7:0]  ldr_wdat;
    logic        ldr_aen;
    logic        ldr_wr;
    logic        ldr_ack = 0;
    logic        ldr_done;
    logic        ldr_overflow;

    ioctl_loader_bridge #(.DEPTH(4), .AW(20), .INDEX(8'h01)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .ldr_addr(ldr_addr),
        .ldr_wdat(ldr_wdat), .ldr_aen(ldr_aen), .ldr_wr(ldr_wr), .ldr_ack(ldr_ack),
        .ldr_done(ldr_done), .ldr_overflow(ldr_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q[$];
    int strobes = 0;
    int ack_en = 1;
    int ack_delay = 0;
    logic prev_wr = 0;
    int wcnt = 0;
    logic [27:0] cur = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core-side model and output monitor.
    always @(negedge clk_sys) begin
        logic [27:0] e;
        if (reset) begin
            prev_wr = 0;
            ldr_ack = 0;
        end else begin
            if (ldr_wr && !prev_wr) begin
                strobes++;
                cur  = {ldr_addr, ldr_wdat};
                wcnt = 0;
                if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("ldr_addr", 32'(ldr_addr), 32'(e[27:8]));
                    chk("ldr_wdat", 32'(ldr_wdat), 32'(e[7:0]));
                end
            end else if (ldr_wr) begin
                wcnt++;
                chk("strobe_stable", 32'({ldr_addr, ldr_wdat}), 32'(cur));
            end
            if (ldr_wr && ack_en != 0 && wcnt >= ack_delay) ldr_ack = 1;
            else if (!ldr_wr) ldr_ack = 0;
            prev_wr = ldr_wr;
        end
    end

    task automatic do_reset();
        @(posedge clk_sys); #1;
        reset = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
        exp_q.delete();
        @(posedge clk_sys); #1;
        reset = 0;
        strobes = 0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(posedge clk_sys); #1;
        ioctl_index = idx; ioctl_download = 1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_it);
        @(posedge clk_sys); #1;
        ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
        if (expect_it) exp_q.push_back({a[19:0], d});
    endtask

    task automatic idle_wr();
        @(posedge clk_sys); #1;
        ioctl_wr = 0;
    endtask

    task automatic end_dl();
        @(posedge clk_sys); #1;
        ioctl_wr = 0; ioctl_download = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!ldr_done && n < budget) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("done_reached", 32'(ldr_done), 1);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushes;
        bit seen_wait;
        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_addr", 32'(ldr_addr), 0);
        chk("rst_wdat", 32'(ldr_wdat), 0);
        chk("rst_aen", 32'(ldr_aen), 0);
        chk("rst_wr", 32'(ldr_wr), 0);
        chk("rst_done", 32'(ldr_done), 0);
        chk("rst_ovf", 32'(ldr_overflow), 0);
        reset = 0;

        // Single byte, one-cycle latency, ack after 2 cycles
        ack_en = 1; ack_delay = 2;
        start_dl(8'h01);
        wr_byte(25'h00010, 8'hA5, 1);
        chk("single_aen_load", 32'(ldr_aen), 1);
        chk("single_wr_before", 32'(ldr_wr), 0);
        idle_wr();
        chk("single_latency", 32'(ldr_wr), 1);
        chk("single_addr", 32'(ldr_addr), 32'h10);
        chk("single_data", 32'(ldr_wdat), 32'hA5);
        end_dl();
        wait_done(50);
        chk("single_aen_done", 32'(ldr_aen), 0);
        chk("single_ovf", 32'(ldr_overflow), 0);
        chk("single_strobes", 32'(strobes), 1);

        // Back-pressure: 16 bytes honouring ioctl_wait, slow ack
        do_reset();
        ack_en = 1; ack_delay = 20;
        start_dl(8'h01);
        pushes = 0; seen_wait = 0;
        for (int c = 0; c < 2000 && pushes < 16; c++) begin
            @(posedge clk_sys); #1;
            if (ioctl_wait && !seen_wait) begin
                seen_wait = 1;
                chk("wait_at_count3", 32'(pushes), 3);
            end
            if (!ioctl_wait) begin
                ioctl_wr = 1; ioctl_addr = 25'h200 + 25'(pushes); ioctl_dout = 8'h30 + 8'(pushes * 7);
                exp_q.push_back({20'h200 + 20'(pushes), 8'h30 + 8'(pushes * 7)});
                pushes++;
            end else ioctl_wr = 0;
        end
        chk("bp_pushes", 32'(pushes), 16);
        chk("bp_wait_seen", 32'(seen_wait), 1);
        end_dl();
        wait_done(2000);
        chk("bp_strobes", 32'(strobes), 16);
        chk("bp_ovf", 32'(ldr_overflow), 0);

        // Overrun: 6 back-to-back writes, no ack
        do_reset();
        ack_en = 0; ack_delay = 1;
        start_dl(8'h01);
        for (int i = 0; i < 6; i++) wr_byte(25'h00400 + 25'(i), 8'hC0 + 8'(i), i < 4);
        idle_wr();
        repeat (3) @(posedge clk_sys);
        #1;
        chk("ovr_ovf", 32'(ldr_overflow), 1);
        chk("ovr_wait", 32'(ioctl_wait), 1);
        ack_en = 1;
        end_dl();
        wait_done(200);
        chk("ovr_strobes", 32'(strobes), 4);

        // Filtering: wrong index, then out-of-range address, then a last byte on the falling edge
        do_reset();
        ack_en = 1; ack_delay = 0;
        start_dl(8'h02);
        wr_byte(25'h00020, 8'h77, 0);
        idle_wr();
        chk("filt_idx_aen", 32'(ldr_aen), 0);
        chk("filt_idx_wr", 32'(ldr_wr), 0);
        chk("filt_idx_ovf", 32'(ldr_overflow), 0);
        end_dl();
        start_dl(8'h01);
        wr_byte(25'h100000, 8'h11, 0);
        idle_wr();
        chk("filt_range_ovf", 32'(ldr_overflow), 1);
        chk("filt_range_wr", 32'(ldr_wr), 0);
        @(posedge clk_sys); #1;
        ioctl_wr = 1; ioctl_addr = 25'h0FFFF; ioctl_dout = 8'h5A; ioctl_download = 0;
        exp_q.push_back({20'h0FFFF, 8'h5A});
        idle_wr();
        wait_done(50);
        chk("filt_strobes", 32'(strobes), 1);

        // Done latch: a later download is ignored
        start_dl(8'h01);
        wr_byte(25'h00030, 8'h99, 0);
        chk("latch_wait", 32'(ioctl_wait), 0);
        idle_wr();
        chk("latch_wr", 32'(ldr_wr), 0);
        chk("latch_done", 32'(ldr_done), 1);
        chk("latch_aen", 32'(ldr_aen), 0);
        end_dl();
        repeat (3) @(posedge clk_sys);
        #1;
        chk("latch_strobes", 32'(strobes), 1);

        // Reset mid-load with 3 queued entries and a strobe outstanding
        do_reset();
        ack_en = 0;
        start_dl(8'h01);
        for (int i = 0; i < 3; i++) wr_byte(25'h00800 + 25'(i), 8'h40 + 8'(i), 1);
        idle_wr();
        chk("mid_wr_high", 32'(ldr_wr), 1);
        @(posedge clk_sys); #1;
        reset = 1; ioctl_download = 0;
        exp_q.delete();
        #1;
        chk("mid_rst_wr", 32'(ldr_wr), 0);
        chk("mid_rst_aen", 32'(ldr_aen), 0);
        chk("mid_rst_addr", 32'(ldr_addr), 0);
        chk("mid_rst_wdat", 32'(ldr_wdat), 0);
        chk("mid_rst_wait", 32'(ioctl_wait), 0);
        chk("mid_rst_done", 32'(ldr_done), 0);
        @(posedge clk_sys); #1;
        reset = 0; strobes = 0; ack_en = 1; ack_delay = 1;
        start_dl(8'h01);
        wr_byte(25'h00123, 8'h3C, 1);
        wr_byte(25'h00124, 8'h3D, 1);
        end_dl();
        wait_done(100);
        chk("reload_strobes", 32'(strobes), 2);
        chk("reload_ovf", 32'(ldr_overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
